order_entry_ctrl: RTL and testbench

//  Keypad-driven order controller feeding display_mux: owns mode, cn_now, qty_now, total_sum.

---
 rtl/order_entry_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_order_entry_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/order_entry_ctrl.sv
// Keypad order-entry controller: item code, quantity, price*qty accumulation, FINISH hold.
// Optional macro ORDER_BACKSPACE_EN enables the BACK key (0xD) in code/quantity entry.
module order_entry_ctrl #(
    parameter int unsigned MAX_QTY    = 99,
    parameter int unsigned MAX_TOTAL  = 131071,
    parameter int unsigned FIN_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [9:0]  price_in,
    output logic [2:0]  mode,
    output logic [9:0]  cn_now,
    output logic [6:0]  qty_now,
    output logic [16:0] total_sum,
    output logic        busy
);

    localparam int unsigned FIN_W = (FIN_CYCLES > 1) ? $clog2(FIN_CYCLES) : 1;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_FINISH = 4'hC;
`ifdef ORDER_BACKSPACE_EN
    localparam logic [3:0] K_BACK   = 4'hD;
`endif

    // Low three bits of each encoding are the mode output; S_ADD shows as qty entry.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0000,
        S_CODE  = 4'b0001,
        S_QTY   = 4'b0010,
        S_TOTAL = 4'b0011,
        S_FIN   = 4'b0100,
        S_ADD   = 4'b1010
    } state_t;

    state_t             r_state;
    logic [9:0]         r_cn;
    logic [6:0]         r_qty;
    logic [16:0]        r_total;
    logic [16:0]        r_prod;
    logic               r_busy;
    logic [FIN_W-1:0]   r_fin_cnt;

    logic               w_key;
    logic               w_is_digit;
    logic [13:0]        w_cn_next;
    logic               w_cn_ok;
    logic [10:0]        w_qty_next;
    logic               w_qty_ok;
    logic [16:0]        w_prod;
    logic [17:0]        w_sum;
    logic [16:0]        w_sum_sat;
`ifdef ORDER_BACKSPACE_EN
    logic [9:0]         w_cn_div;
    logic [6:0]         w_qty_div;
`endif

    always_comb begin
        w_key      = key_valid && !r_busy;
        w_is_digit = (key_code <= 4'd9);
        w_cn_next  = 14'(r_cn) * 14'd10 + 14'(key_code);
        w_cn_ok    = (w_cn_next <= 14'd1023);
        w_qty_next = 11'(r_qty) * 11'd10 + 11'(key_code);
        w_qty_ok   = (w_qty_next <= 11'(MAX_QTY));
        w_prod     = 17'(price_in) * 17'(r_qty);
        w_sum      = {1'b0, r_total} + {1'b0, r_prod};
        w_sum_sat  = (w_sum > 18'(MAX_TOTAL)) ? 17'(MAX_TOTAL) : w_sum[16:0];
`ifdef ORDER_BACKSPACE_EN
        w_cn_div   = r_cn / 10'd10;
        w_qty_div  = r_qty / 7'd10;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cn      <= '0;
            r_qty     <= '0;
            r_total   <= '0;
            r_prod    <= '0;
            r_busy    <= 1'b0;
            r_fin_cnt <= '0;
        end else begin
            unique case (r_state)
                S_FIN: begin
                    // Timeout takes priority; keys are never looked at here.
                    if (r_fin_cnt == FIN_W'(FIN_CYCLES - 1)) begin
                        r_state   <= S_IDLE;
                        r_cn      <= '0;
                        r_qty     <= '0;
                        r_total   <= '0;
                        r_fin_cnt <= '0;
                    end else begin
                        r_fin_cnt <= r_fin_cnt + 1'b1;
                    end
                end
                S_ADD: begin
                    r_total <= w_sum_sat;
                    r_busy  <= 1'b0;
                    r_state <= S_TOTAL;
                end
                S_IDLE: begin
                    if (w_key) begin
                        if (w_is_digit) begin
                            r_cn    <= 10'(key_code);
                            r_state <= S_CODE;
                        end else if (key_code == K_ENTER || key_code == K_CLEAR ||
                                     key_code == K_FINISH) begin
                            r_state <= S_CODE;
                        end
                    end
                end
                S_CODE: begin
                    if (w_key) begin
                        if (w_is_digit) begin
                            if (w_cn_ok) r_cn <= w_cn_next[9:0];
                        end else if (key_code == K_ENTER) begin
                            if (r_cn != '0) begin
                                r_qty   <= '0;
                                r_state <= S_QTY;
                            end
                        end else if (key_code == K_CLEAR) begin
                            if (r_cn != '0)        r_cn    <= '0;
                            else if (r_total != '0) r_state <= S_TOTAL;
                            else                   r_state <= S_IDLE;
                        end else if (key_code == K_FINISH) begin
                            if (r_total != '0) begin
                                r_fin_cnt <= '0;
                                r_state   <= S_FIN;
                            end
`ifdef ORDER_BACKSPACE_EN
                        end else if (key_code == K_BACK) begin
                            r_cn <= w_cn_div;
`endif
                        end
                    end
                end
                S_QTY: begin
                    if (w_key) begin
                        if (w_is_digit) begin
                            if (w_qty_ok) r_qty <= w_qty_next[6:0];
                        end else if (key_code == K_ENTER) begin
                            if (r_qty != '0) begin
                                r_prod  <= w_prod;
                                r_busy  <= 1'b1;
                                r_state <= S_ADD;
                            end
                        end else if (key_code == K_CLEAR) begin
                            if (r_qty != '0) r_qty   <= '0;
                            else             r_state <= S_CODE;
`ifdef ORDER_BACKSPACE_EN
                        end else if (key_code == K_BACK) begin
                            r_qty <= w_qty_div;
`endif
                        end
                    end
                end
                S_TOTAL: begin
                    if (w_key) begin
                        if (w_is_digit) begin
                            r_cn    <= 10'(key_code);
                            r_qty   <= '0;
                            r_state <= S_CODE;
                        end else if (key_code == K_ENTER) begin
                            r_cn    <= '0;
                            r_qty   <= '0;
                            r_state <= S_CODE;
                        end else if (key_code == K_FINISH) begin
                            r_fin_cnt <= '0;
                            r_state   <= S_FIN;
                        end else if (key_code == K_CLEAR) begin
                            r_total <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mode      = r_state[2:0];
    assign cn_now    = r_cn;
    assign qty_now   = r_qty;
    assign total_sum = r_total;
    assign busy      = r_busy;

endmodule

// File: tb/tb_order_entry_ctrl.sv
// Self-checking bench for order_entry_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_order_entry_ctrl;

    localparam int unsigned FIN_N = 20;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [9:0]  price_in;
    logic [2:0]  mode;
    logic [9:0]  cn_now;
    logic [6:0]  qty_now;
    logic [16:0] total_sum;
    logic        busy;

    order_entry_ctrl #(
        .MAX_QTY    (99),
        .MAX_TOTAL  (131071),
        .FIN_CYCLES (FIN_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .price_in  (price_in),
        .mode      (mode),
        .cn_now    (cn_now),
        .qty_now   (qty_now),
        .total_sum (total_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  k;
        logic [9:0]  p;
        logic [2:0]  m;
        logic [9:0]  cn;
        logic [6:0]  q;
        logic [16:0] t;
        logic        b;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[21];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic v, input logic [3:0] k, input logic [9:0] p,
                                input logic [2:0] m, input int cn, input int q,
                                input int t, input logic b);
        vec_t x;
        x.v = v; x.k = k; x.p = p; x.m = m;
        x.cn = 10'(cn); x.q = 7'(q); x.t = 17'(t); x.b = b;
        return x;
    endfunction

    task automatic compare(input string nm);
        vec_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, nothing expected", nm);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if ({mode, cn_now, qty_now, total_sum, busy} !== {e.m, e.cn, e.q, e.t, e.b}) begin
            n_fail++;
            $display("FAIL %s: got mode=%0d cn=%0d qty=%0d total=%0d busy=%0d, expected mode=%0d cn=%0d qty=%0d total=%0d busy=%0d",
                     nm, mode, cn_now, qty_now, total_sum, busy, e.m, e.cn, e.q, e.t, e.b);
        end
    endtask

    task automatic step(input string nm, input vec_t x);
        @(negedge clk);
        key_valid = x.v;
        key_code  = x.k;
        price_in  = x.p;
        sb.push_back(x);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        compare(nm);
    endtask

    initial begin
        int unsigned bs_exp;
        rst_n = 1'b0; key_valid = 1'b0; key_code = '0; price_in = '0;
        repeat (2) @(negedge clk);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        compare("reset_state");
        rst_n = 1'b1;

        // 12 then qty 3 at price 150 -> 450; then code digit limit, qty limit, CLEAR chain
        tbl[0]  = mk(0, 4'h0, 150, 0, 0,   0,  0,   0);
        tbl[1]  = mk(1, 4'h1, 150, 1, 1,   0,  0,   0);
        tbl[2]  = mk(1, 4'h2, 150, 1, 12,  0,  0,   0);
        tbl[3]  = mk(1, 4'hA, 150, 2, 12,  0,  0,   0);
        tbl[4]  = mk(1, 4'h3, 150, 2, 12,  3,  0,   0);
        tbl[5]  = mk(1, 4'hA, 150, 2, 12,  3,  0,   1);
        tbl[6]  = mk(0, 4'h0, 150, 3, 12,  3,  450, 0);
        tbl[7]  = mk(1, 4'hE, 150, 3, 12,  3,  450, 0);
        tbl[8]  = mk(1, 4'h1, 150, 1, 1,   0,  450, 0);
        tbl[9]  = mk(1, 4'h0, 150, 1, 10,  0,  450, 0);
        tbl[10] = mk(1, 4'h2, 150, 1, 102, 0,  450, 0);
        tbl[11] = mk(1, 4'h4, 150, 1, 102, 0,  450, 0);
        tbl[12] = mk(1, 4'hA, 150, 2, 102, 0,  450, 0);
        tbl[13] = mk(1, 4'h9, 150, 2, 102, 9,  450, 0);
        tbl[14] = mk(1, 4'h9, 150, 2, 102, 99, 450, 0);
        tbl[15] = mk(1, 4'h9, 150, 2, 102, 99, 450, 0);
        tbl[16] = mk(1, 4'hB, 150, 2, 102, 0,  450, 0);
        tbl[17] = mk(1, 4'hB, 150, 1, 102, 0,  450, 0);
        tbl[18] = mk(1, 4'hB, 150, 1, 0,   0,  450, 0);
        tbl[19] = mk(1, 4'hB, 150, 3, 0,   0,  450, 0);
        tbl[20] = mk(1, 4'hB, 150, 0, 0,   0,  0,   0);
        for (int i = 0; i < 21; i++) step($sformatf("vec%0d", i), tbl[i]);

        // Accumulate to 131000, then saturate and stay saturated
        step("sat_k1",    mk(1, 4'h1, 0,    1, 1, 0,  0,      0));
        step("sat_ent",   mk(1, 4'hA, 0,    2, 1, 0,  0,      0));
        step("sat_q9",    mk(1, 4'h9, 0,    2, 1, 9,  0,      0));
        step("sat_q99",   mk(1, 4'h9, 0,    2, 1, 99, 0,      0));
        step("sat_add1",  mk(1, 4'hA, 1000, 2, 1, 99, 0,      1));
        step("sat_tot1",  mk(0, 4'h0, 1000, 3, 1, 99, 99000,  0));
        step("sat_k1b",   mk(1, 4'h1, 1000, 1, 1, 0,  99000,  0));
        step("sat_entb",  mk(1, 4'hA, 1000, 2, 1, 0,  99000,  0));
        step("sat_q3",    mk(1, 4'h3, 1000, 2, 1, 3,  99000,  0));
        step("sat_q32",   mk(1, 4'h2, 1000, 2, 1, 32, 99000,  0));
        step("sat_add2",  mk(1, 4'hA, 1000, 2, 1, 32, 99000,  1));
        step("sat_tot2",  mk(0, 4'h0, 1000, 3, 1, 32, 131000, 0));
        step("sat_ent0",  mk(1, 4'hA, 100,  1, 0, 0,  131000, 0));
        step("sat_k5",    mk(1, 4'h5, 100,  1, 5, 0,  131000, 0));
        step("sat_entc",  mk(1, 4'hA, 100,  2, 5, 0,  131000, 0));
        step("sat_q5",    mk(1, 4'h5, 100,  2, 5, 5,  131000, 0));
        step("sat_add3",  mk(1, 4'hA, 100,  2, 5, 5,  131000, 1));
        step("sat_clamp", mk(0, 4'h0, 100,  3, 5, 5,  131071, 0));
        step("sat_k5b",   mk(1, 4'h5, 1,    1, 5, 0,  131071, 0));
        step("sat_entd",  mk(1, 4'hA, 1,    2, 5, 0,  131071, 0));
        step("sat_q1",    mk(1, 4'h1, 1,    2, 5, 1,  131071, 0));
        step("sat_add4",  mk(1, 4'hA, 1,    2, 5, 1,  131071, 1));
        step("busy_drop", mk(1, 4'hB, 1,    3, 5, 1,  131071, 0));

        // FINISH hold: keys ignored for FIN_N clocks, then timeout beats a simultaneous key
        step("fin_enter", mk(1, 4'hC, 0, 4, 5, 1, 131071, 0));
        for (int i = 1; i < FIN_N; i++)
            step($sformatf("fin_hold%0d", i), mk(1, 4'(i % 12), 0, 4, 5, 1, 131071, 0));
        step("fin_exit",  mk(1, 4'h1, 0, 0, 0, 0, 0, 0));

        // CLEAR chain from QTY with total 0; FINISH with total 0 ignored
        step("cc_k5",    mk(1, 4'h5, 0, 1, 5, 0, 0, 0));
        step("cc_ent",   mk(1, 4'hA, 0, 2, 5, 0, 0, 0));
        step("cc_enq0",  mk(1, 4'hA, 0, 2, 5, 0, 0, 0));
        step("cc_q7",    mk(1, 4'h7, 0, 2, 5, 7, 0, 0));
        step("cc_fin_q", mk(1, 4'hC, 0, 2, 5, 7, 0, 0));
        step("cc_clr1",  mk(1, 4'hB, 0, 2, 5, 0, 0, 0));
        step("cc_clr2",  mk(1, 4'hB, 0, 1, 5, 0, 0, 0));
        step("cc_clr3",  mk(1, 4'hB, 0, 1, 0, 0, 0, 0));
        step("cc_fin_c", mk(1, 4'hC, 0, 1, 0, 0, 0, 0));
        step("cc_ent0",  mk(1, 4'hA, 0, 1, 0, 0, 0, 0));
        step("cc_clr4",  mk(1, 4'hB, 0, 0, 0, 0, 0, 0));
        step("idle_bk",  mk(1, 4'hD, 0, 0, 0, 0, 0, 0));

        // BACK key behaviour depends on build configuration
`ifdef ORDER_BACKSPACE_EN
        bs_exp = 45;
`else
        bs_exp = 456;
`endif
        step("bs_k4",   mk(1, 4'h4, 0, 1, 4,   0, 0, 0));
        step("bs_k5",   mk(1, 4'h5, 0, 1, 45,  0, 0, 0));
        step("bs_k6",   mk(1, 4'h6, 0, 1, 456, 0, 0, 0));
        step("bs_back", mk(1, 4'hD, 0, 1, int'(bs_exp), 0, 0, 0));

        // Reset while the accumulate is in flight
        step("rst_ent", mk(1, 4'hA, 150, 2, int'(bs_exp), 0, 0, 0));
        step("rst_q3",  mk(1, 4'h3, 150, 2, int'(bs_exp), 3, 0, 0));
        step("rst_add", mk(1, 4'hA, 150, 2, int'(bs_exp), 3, 0, 1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        compare("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_nolate", mk(0, 4'h0, 150, 0, 0, 0, 0, 0));
        step("rst_nolate2", mk(0, 4'h0, 150, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
